// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter (LSB first).
// Bytes written by the IO stage are queued and serialised on txd at
// CLKS_PER_BIT clocks per bit. Status flags tx_ready/tsre expose FIFO space
// and transmitter idleness for the CPU's serial status register.
`timescale 1ns/1ps
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 96,
   parameter int ADDR_W       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       tx_ready,
   output logic       tsre,
   output logic       overflow,
   output logic       txd
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   count_reg;
   logic [ADDR_W:0]   count_next;
   logic              overflow_reg;

   // transmitter state
   state_t            state_reg;
   state_t            state_next;
   logic [BAUD_W-1:0] baud_reg;
   logic [BAUD_W-1:0] baud_next;
   logic [2:0]        bit_reg;
   logic [2:0]        bit_next;
   logic [2:0]        bit_inc;
   logic [7:0]        sh_reg;
   logic              txd_reg;
   logic              txd_next;
   logic              tsre_reg;

   logic              full;
   logic              wr_acc;
   logic              pop;
   logic              baud_wrap;

   // Fullness is judged from the registered count, so a pop in the same
   // cycle never rescues a write that arrives while full.
   assign full      = (count_reg == FULL_CNT);
   assign tx_ready  = ~full;
   assign wr_acc    = wr_en & ~full;
   assign baud_wrap = (baud_reg == BAUD_LAST);
   assign bit_inc   = bit_reg + 3'd1;

   assign txd      = txd_reg;
   assign tsre     = tsre_reg;
   assign overflow = overflow_reg;

   // Queue storage: written on accepted writes, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Occupancy after this cycle's accepted write and/or pop.
   always_comb begin
      count_next = count_reg;
      case ({wr_acc, pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   // FIFO pointers, count and the one-cycle dropped-write pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         count_reg    <= count_next;
         overflow_reg <= wr_en & full;
      end
   end

   // Frame sequencer: next state, baud/bit counters, next txd level and pop.
   // txd_next is the level the line takes from the coming edge onward, so the
   // line itself always comes straight from a flop.
   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      txd_next   = txd_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            txd_next = 1'b1;
            if (count_reg != '0) begin
               pop        = 1'b1;
               baud_next  = '0;
               state_next = START;
               txd_next   = 1'b0;
            end
         end
         START: begin
            if (baud_wrap) begin
               baud_next  = '0;
               bit_next   = 3'd0;
               state_next = DATA;
               txd_next   = sh_reg[0];
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               baud_next = '0;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end else begin
                  bit_next = bit_inc;
                  txd_next = sh_reg[bit_inc];
               end
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_wrap) begin
               baud_next = '0;
               // Chain straight into the next start bit when data is queued.
               if (count_reg != '0) begin
                  pop        = 1'b1;
                  state_next = START;
                  txd_next   = 1'b0;
               end else begin
                  state_next = IDLE;
                  txd_next   = 1'b1;
               end
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            baud_next  = '0;
            txd_next   = 1'b1;
         end
      endcase
   end

   // Sequencer registers; tsre is registered from next-state values so it
   // tracks the same edge at which the FSM and FIFO change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= 3'd0;
         sh_reg    <= 8'h00;
         txd_reg   <= 1'b1;
         tsre_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         txd_reg   <= txd_next;
         tsre_reg  <= (state_next == IDLE) && (count_next == '0);
         if (pop) begin
            sh_reg <= mem[rd_ptr_reg];
         end
      end
   end

endmodule
